// File: rtl/dma_desc_processor.sv
// rtl/dma_desc_processor.sv - splits copy descriptors into destination-aligned read/write command pairs
module dma_desc_processor #(
  parameter int MAX_CHUNK_BYTES = 1024,
  parameter int CHUNK_LOG2      = $clog2(MAX_CHUNK_BYTES)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        desc_valid_i,
  output logic        desc_ready_o,
  input  logic [31:0] desc_src_addr_i,
  input  logic [31:0] desc_dst_addr_i,
  input  logic [15:0] desc_length_i,
  output logic        dma_rd_fifo_command_req_o,
  output logic [31:0] dma_rd_addr_o,
  output logic [15:0] dma_rd_bytes_to_transfer_o,
  input  logic        dma_rd_fifo_full_i,
  output logic        dma_wr_fifo_command_req_o,
  output logic [31:0] dma_wr_addr_o,
  output logic [15:0] dma_wr_bytes_to_transfer_o,
  input  logic        dma_wr_fifo_full_i,
  output logic        busy_o,
  output logic        desc_done_o,
  output logic [15:0] chunk_count_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    ISSUE = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] src;
  logic [31:0] dst;
  logic [15:0] rem;
  logic [15:0] chunk;

  logic [15:0] room;
  logic [15:0] chunk_next;

  // Only the destination offset limits the chunk; the source simply follows along.
  always_comb begin
    room       = 16'(MAX_CHUNK_BYTES) - 16'(dst[CHUNK_LOG2-1:0]);
    chunk_next = (rem < room) ? rem : room;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                      <= IDLE;
      src                        <= '0;
      dst                        <= '0;
      rem                        <= '0;
      chunk                      <= '0;
      desc_ready_o               <= 1'b0;
      dma_rd_fifo_command_req_o  <= 1'b0;
      dma_rd_addr_o              <= '0;
      dma_rd_bytes_to_transfer_o <= '0;
      dma_wr_fifo_command_req_o  <= 1'b0;
      dma_wr_addr_o              <= '0;
      dma_wr_bytes_to_transfer_o <= '0;
      busy_o                     <= 1'b0;
      desc_done_o                <= 1'b0;
      chunk_count_o              <= '0;
    end else begin
      dma_rd_fifo_command_req_o <= 1'b0;
      dma_wr_fifo_command_req_o <= 1'b0;
      desc_done_o               <= 1'b0;
      case (state)
        IDLE: begin
          desc_ready_o <= 1'b1;
          if (desc_valid_i && desc_ready_o) begin
            src           <= desc_src_addr_i;
            dst           <= desc_dst_addr_i;
            rem           <= desc_length_i;
            chunk_count_o <= '0;
            desc_ready_o  <= 1'b0;
            busy_o        <= 1'b1;
            state         <= CALC;
          end
        end
        CALC: begin
          if (rem == 16'd0) begin
            desc_done_o <= 1'b1;
            state       <= DONE;
          end else begin
            chunk <= chunk_next;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          // Both pushes go out together so the read and write queues stay paired.
          if (!(dma_rd_fifo_full_i || dma_wr_fifo_full_i)) begin
            dma_rd_fifo_command_req_o  <= 1'b1;
            dma_wr_fifo_command_req_o  <= 1'b1;
            dma_rd_addr_o              <= src;
            dma_wr_addr_o              <= dst;
            dma_rd_bytes_to_transfer_o <= chunk;
            dma_wr_bytes_to_transfer_o <= chunk;
            state                      <= GAP;
          end
        end
        GAP: begin
          src           <= src + {16'd0, chunk};
          dst           <= dst + {16'd0, chunk};
          rem           <= rem - chunk;
          chunk_count_o <= chunk_count_o + 16'd1;
          state         <= CALC;
        end
        DONE: begin
          busy_o       <= 1'b0;
          desc_ready_o <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_desc_processor.sv
// tb/tb_dma_desc_processor.sv - directed self-checking bench for dma_desc_processor
module tb_dma_desc_processor;

  logic        clk = 1'b0;
  logic        reset;
  logic        desc_valid_i;
  logic        desc_ready_o;
  logic [31:0] desc_src_addr_i;
  logic [31:0] desc_dst_addr_i;
  logic [15:0] desc_length_i;
  logic        dma_rd_fifo_command_req_o;
  logic [31:0] dma_rd_addr_o;
  logic [15:0] dma_rd_bytes_to_transfer_o;
  logic        dma_rd_fifo_full_i;
  logic        dma_wr_fifo_command_req_o;
  logic [31:0] dma_wr_addr_o;
  logic [15:0] dma_wr_bytes_to_transfer_o;
  logic        dma_wr_fifo_full_i;
  logic        busy_o;
  logic        desc_done_o;
  logic [15:0] chunk_count_o;

  dma_desc_processor #(.MAX_CHUNK_BYTES(1024)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .desc_valid_i               (desc_valid_i),
    .desc_ready_o               (desc_ready_o),
    .desc_src_addr_i            (desc_src_addr_i),
    .desc_dst_addr_i            (desc_dst_addr_i),
    .desc_length_i              (desc_length_i),
    .dma_rd_fifo_command_req_o  (dma_rd_fifo_command_req_o),
    .dma_rd_addr_o              (dma_rd_addr_o),
    .dma_rd_bytes_to_transfer_o (dma_rd_bytes_to_transfer_o),
    .dma_rd_fifo_full_i         (dma_rd_fifo_full_i),
    .dma_wr_fifo_command_req_o  (dma_wr_fifo_command_req_o),
    .dma_wr_addr_o              (dma_wr_addr_o),
    .dma_wr_bytes_to_transfer_o (dma_wr_bytes_to_transfer_o),
    .dma_wr_fifo_full_i         (dma_wr_fifo_full_i),
    .busy_o                     (busy_o),
    .desc_done_o                (desc_done_o),
    .chunk_count_o              (chunk_count_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  int          push_cyc[$];
  logic [31:0] push_rd[$];
  logic [31:0] push_wr[$];
  logic [31:0] push_bytes[$];
  int          done_cnt = 0;
  int          acc_cyc;
  int          done_cyc;

  always @(negedge clk) begin
    if (dma_rd_fifo_command_req_o || dma_wr_fifo_command_req_o) begin
      check("req_pair", {31'd0, dma_rd_fifo_command_req_o}, {31'd0, dma_wr_fifo_command_req_o});
      check("bytes_pair", {16'd0, dma_rd_bytes_to_transfer_o}, {16'd0, dma_wr_bytes_to_transfer_o});
      push_cyc.push_back(cyc);
      push_rd.push_back(dma_rd_addr_o);
      push_wr.push_back(dma_wr_addr_o);
      push_bytes.push_back({16'd0, dma_rd_bytes_to_transfer_o});
    end
    if (desc_done_o) done_cnt++;
  end

  task automatic clear_logs();
    push_cyc.delete();
    push_rd.delete();
    push_wr.delete();
    push_bytes.delete();
    done_cnt = 0;
  endtask

  task automatic send_desc(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    @(negedge clk);
    desc_valid_i    = 1'b1;
    desc_src_addr_i = s;
    desc_dst_addr_i = d;
    desc_length_i   = l;
    for (int i = 0; i < 50 && !desc_ready_o; i++) @(negedge clk);
    check("accept_ready", {31'd0, desc_ready_o}, 32'd1);
    acc_cyc = cyc;
    @(negedge clk);
    desc_valid_i = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 200; i++) begin
      if (desc_done_o) begin
        dc = cyc;
        break;
      end
      @(negedge clk);
    end
    check("done_seen", {31'd0, dc != -1}, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, desc_ready_o}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    check({tag, "_req"}, {30'd0, dma_rd_fifo_command_req_o, dma_wr_fifo_command_req_o}, 32'd0);
    check({tag, "_rd_addr"}, dma_rd_addr_o, 32'd0);
    check({tag, "_wr_addr"}, dma_wr_addr_o, 32'd0);
    check({tag, "_bytes"}, {dma_rd_bytes_to_transfer_o, dma_wr_bytes_to_transfer_o}, 32'd0);
    check({tag, "_done"}, {31'd0, desc_done_o}, 32'd0);
    check({tag, "_count"}, {16'd0, chunk_count_o}, 32'd0);
  endtask

  initial begin
    reset              = 1'b1;
    desc_valid_i       = 1'b0;
    desc_src_addr_i    = '0;
    desc_dst_addr_i    = '0;
    desc_length_i      = '0;
    dma_rd_fifo_full_i = 1'b0;
    dma_wr_fifo_full_i = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("rst");
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready_after", {31'd0, desc_ready_o}, 32'd1);

    // Destination 0x300 into a 1 KiB window: 0x100 then 0x400.
    clear_logs();
    send_desc(32'h2000_0000, 32'h1000_0F00, 16'h0500);
    wait_done(done_cyc);
    @(negedge clk);
    check("a_npush", push_cyc.size(), 2);
    if (push_cyc.size() == 2) begin
      check("a_rd0", push_rd[0], 32'h2000_0000);
      check("a_wr0", push_wr[0], 32'h1000_0F00);
      check("a_by0", push_bytes[0], 32'h100);
      check("a_rd1", push_rd[1], 32'h2000_0100);
      check("a_wr1", push_wr[1], 32'h1000_1000);
      check("a_by1", push_bytes[1], 32'h400);
      check("a_lat0", push_cyc[0] - acc_cyc, 3);
      check("a_gap", push_cyc[1] - push_cyc[0], 3);
      check("a_done_lat", done_cyc - push_cyc[1], 2);
    end
    check("a_done_cnt", done_cnt, 1);
    check("a_chunks", {16'd0, chunk_count_o}, 32'd2);

    // Short aligned copy: one push of 37 bytes.
    clear_logs();
    send_desc(32'h3000_0000, 32'h0000_0000, 16'd37);
    wait_done(done_cyc);
    @(negedge clk);
    check("b_npush", push_cyc.size(), 1);
    if (push_cyc.size() == 1) begin
      check("b_rd", push_rd[0], 32'h3000_0000);
      check("b_wr", push_wr[0], 32'h0);
      check("b_by", push_bytes[0], 32'd37);
      check("b_lat", push_cyc[0] - acc_cyc, 3);
      check("b_done_lat", done_cyc - push_cyc[0], 2);
    end
    check("b_chunks", {16'd0, chunk_count_o}, 32'd1);

    // Zero length: done two cycles after accept, ready again the cycle after.
    clear_logs();
    send_desc(32'h1234_0000, 32'h5678_0000, 16'd0);
    wait_done(done_cyc);
    check("c_done_lat", done_cyc - acc_cyc, 2);
    @(negedge clk);
    check("c_ready_back", {31'd0, desc_ready_o}, 32'd1);
    check("c_npush", push_cyc.size(), 0);
    check("c_chunks", {16'd0, chunk_count_o}, 32'd0);

    // Write FIFO full for the first 10 ISSUE cycles.
    clear_logs();
    dma_wr_fifo_full_i = 1'b1;
    send_desc(32'h4000_0000, 32'h5000_0000, 16'd64);
    repeat (11) @(negedge clk);
    check("d_stall_npush", push_cyc.size(), 0);
    check("d_stall_busy", {31'd0, busy_o}, 32'd1);
    check("d_stall_ready", {31'd0, desc_ready_o}, 32'd0);
    dma_wr_fifo_full_i = 1'b0;
    wait_done(done_cyc);
    @(negedge clk);
    check("d_npush", push_cyc.size(), 1);
    if (push_cyc.size() == 1) begin
      check("d_lat", push_cyc[0] - acc_cyc, 13);
      check("d_rd", push_rd[0], 32'h4000_0000);
      check("d_wr", push_wr[0], 32'h5000_0000);
      check("d_by", push_bytes[0], 32'd64);
    end

    // Four full chunks, destination wrapping through 2^32.
    clear_logs();
    send_desc(32'h6000_0000, 32'hFFFF_FC00, 16'h1000);
    wait_done(done_cyc);
    @(negedge clk);
    check("e_npush", push_cyc.size(), 4);
    if (push_cyc.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("e_rd", push_rd[i], 32'h6000_0000 + 32'h400 * i);
        check("e_wr", push_wr[i], 32'hFFFF_FC00 + 32'h400 * i);
        check("e_by", push_bytes[i], 32'h400);
        if (i > 0) check("e_gap", push_cyc[i] - push_cyc[i-1], 3);
      end
      check("e_wr_wrap", push_wr[1], 32'h0000_0000);
      check("e_done_lat", done_cyc - push_cyc[3], 2);
    end
    check("e_chunks", {16'd0, chunk_count_o}, 32'd4);

    // Reset right after the first push of a four-chunk descriptor.
    clear_logs();
    send_desc(32'h7000_0000, 32'h0000_0000, 16'h1000);
    begin
      int seen = 0;
      for (int i = 0; i < 50; i++) begin
        if (dma_rd_fifo_command_req_o) begin
          seen = 1;
          break;
        end
        @(negedge clk);
      end
      check("f_first_push", seen, 1);
    end
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("f_rst");
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("f_npush", push_cyc.size(), 1);
    check("f_no_done", done_cnt, 0);
    clear_logs();
    send_desc(32'h0000_0100, 32'h0000_0020, 16'd32);
    wait_done(done_cyc);
    @(negedge clk);
    check("f2_npush", push_cyc.size(), 1);
    if (push_cyc.size() == 1) begin
      check("f2_rd", push_rd[0], 32'h100);
      check("f2_wr", push_wr[0], 32'h20);
      check("f2_by", push_bytes[0], 32'd32);
    end
    check("f2_done_cnt", done_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
